jt51_reg_ring: RTL and testbench

- Parameter store and slot sequencer for the JT51 FM core.
- Holds per-channel (8) and per-operator (32) voice registers written by the memory-mapped register front end.
- Keeps a 5-bit slot counter advancing on each cen.
- Presents each slot's parameters to downstream pipeline stages at fixed stage offsets, together with algorithm-routing flags.

---
 rtl/jt51_reg_ring.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_jt51_reg_ring.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jt51_reg_ring.sv
// JT51 voice parameter store and slot sequencer.
// Per-slot parameters are presented at fixed pipeline stage offsets.
module jt51_reg_ring (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic       up_rl,
    input  logic       up_kc,
    input  logic       up_kf,
    input  logic       up_pms,
    input  logic       up_dt1,
    input  logic       up_tl,
    input  logic       up_ks,
    input  logic       up_amsen,
    input  logic       up_dt2,
    input  logic       up_d1l,
    input  logic       up_keyon,
    input  logic [1:0] op,
    input  logic [2:0] ch,
    input  logic       csm,
    input  logic       overflow_A,
    output logic [1:0] rl_I,
    output logic [2:0] fb_II,
    output logic [2:0] con_I,
    output logic [6:0] kc_I,
    output logic [5:0] kf_I,
    output logic [2:0] pms_I,
    output logic [1:0] ams_VII,
    output logic [2:0] dt1_II,
    output logic [1:0] dt2_I,
    output logic [3:0] mul_VI,
    output logic [6:0] tl_VII,
    output logic [1:0] ks_III,
    output logic [4:0] arate_II,
    output logic       amsen_VII,
    output logic [4:0] rate1_II,
    output logic [4:0] rate2_II,
    output logic [3:0] rrate_II,
    output logic [3:0] d1l_I,
    output logic       keyon_II,
    output logic [1:0] cur_op,
    output logic       op31_no,
    output logic       op31_acc,
    output logic       zero,
    output logic       half,
    output logic [4:0] cycles,
    output logic       m1_enters,
    output logic       m2_enters,
    output logic       c1_enters,
    output logic       c2_enters,
    output logic       use_prevprev1,
    output logic       use_internal_x,
    output logic       use_internal_y,
    output logic       use_prev2,
    output logic       use_prev1
);

    logic [4:0] cycles_q, cycles_d;

    logic [7:0][1:0] rl_q, rl_d;
    logic [7:0][2:0] fb_q, fb_d;
    logic [7:0][2:0] con_q, con_d;
    logic [7:0][6:0] kc_q, kc_d;
    logic [7:0][5:0] kf_q, kf_d;
    logic [7:0][2:0] pms_q, pms_d;
    logic [7:0][1:0] ams_q, ams_d;

    logic [31:0][2:0] dt1_q, dt1_d;
    logic [31:0][3:0] mul_q, mul_d;
    logic [31:0][6:0] tl_q, tl_d;
    logic [31:0][1:0] ks_q, ks_d;
    logic [31:0][4:0] ar_q, ar_d;
    logic [31:0]      amsen_q, amsen_d;
    logic [31:0][4:0] d1r_q, d1r_d;
    logic [31:0][4:0] d2r_q, d2r_d;
    logic [31:0][1:0] dt2_q, dt2_d;
    logic [31:0][3:0] d1l_q, d1l_d;
    logic [31:0][3:0] rr_q, rr_d;
    logic [31:0]      kon_q, kon_d;

    logic       csm_kon_q, csm_kon_d;
    logic [4:0] csm_cnt_q, csm_cnt_d;

    logic [4:0] opsel;
    logic [2:0] kch;
    logic [4:0] s_ii, s_iii, s_vi, s_vii;

    assign opsel = {op, ch};
    assign kch   = din[2:0];
    assign s_ii  = cycles_q - 5'd1;
    assign s_iii = cycles_q - 5'd2;
    assign s_vi  = cycles_q - 5'd5;
    assign s_vii = cycles_q - 5'd6;

    always_comb begin
        cycles_d = cycles_q;
        if (cen) cycles_d = cycles_q + 5'd1;
    end

    // Register writes are independent of cen: the bus can land any cycle.
    always_comb begin
        rl_d  = rl_q;
        fb_d  = fb_q;
        con_d = con_q;
        kc_d  = kc_q;
        kf_d  = kf_q;
        pms_d = pms_q;
        ams_d = ams_q;
        if (up_rl) begin
            rl_d[ch]  = din[7:6];
            fb_d[ch]  = din[5:3];
            con_d[ch] = din[2:0];
        end
        if (up_kc) kc_d[ch] = din[6:0];
        if (up_kf) kf_d[ch] = din[7:2];
        if (up_pms) begin
            pms_d[ch] = din[6:4];
            ams_d[ch] = din[1:0];
        end
    end

    always_comb begin
        dt1_d   = dt1_q;
        mul_d   = mul_q;
        tl_d    = tl_q;
        ks_d    = ks_q;
        ar_d    = ar_q;
        amsen_d = amsen_q;
        d1r_d   = d1r_q;
        d2r_d   = d2r_q;
        dt2_d   = dt2_q;
        d1l_d   = d1l_q;
        rr_d    = rr_q;
        kon_d   = kon_q;
        if (up_dt1) begin
            dt1_d[opsel] = din[6:4];
            mul_d[opsel] = din[3:0];
        end
        if (up_tl) tl_d[opsel] = din[6:0];
        if (up_ks) begin
            ks_d[opsel] = din[7:6];
            ar_d[opsel] = din[4:0];
        end
        if (up_amsen) begin
            amsen_d[opsel] = din[7];
            d1r_d[opsel]   = din[4:0];
        end
        if (up_dt2) begin
            dt2_d[opsel] = din[7:6];
            d2r_d[opsel] = din[4:0];
        end
        if (up_d1l) begin
            d1l_d[opsel] = din[7:4];
            rr_d[opsel]  = din[3:0];
        end
        // Key-on byte order is M1, C1, M2, C2 in bits 3..6.
        if (up_keyon) begin
            kon_d[{2'd0, kch}] = din[3];
            kon_d[{2'd2, kch}] = din[4];
            kon_d[{2'd1, kch}] = din[5];
            kon_d[{2'd3, kch}] = din[6];
        end
    end

    always_comb begin
        csm_kon_d = csm_kon_q;
        csm_cnt_d = csm_cnt_q;
        if (csm && overflow_A) begin
            csm_kon_d = 1'b1;
            csm_cnt_d = 5'd0;
        end else if (cen && csm_kon_q) begin
            csm_cnt_d = csm_cnt_q + 5'd1;
            if (csm_cnt_q == 5'd31) csm_kon_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q  <= '0;
            rl_q      <= '0;
            fb_q      <= '0;
            con_q     <= '0;
            kc_q      <= '0;
            kf_q      <= '0;
            pms_q     <= '0;
            ams_q     <= '0;
            dt1_q     <= '0;
            mul_q     <= '0;
            tl_q      <= '0;
            ks_q      <= '0;
            ar_q      <= '0;
            amsen_q   <= '0;
            d1r_q     <= '0;
            d2r_q     <= '0;
            dt2_q     <= '0;
            d1l_q     <= '0;
            rr_q      <= '0;
            kon_q     <= '0;
            csm_kon_q <= 1'b0;
            csm_cnt_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            rl_q      <= rl_d;
            fb_q      <= fb_d;
            con_q     <= con_d;
            kc_q      <= kc_d;
            kf_q      <= kf_d;
            pms_q     <= pms_d;
            ams_q     <= ams_d;
            dt1_q     <= dt1_d;
            mul_q     <= mul_d;
            tl_q      <= tl_d;
            ks_q      <= ks_d;
            ar_q      <= ar_d;
            amsen_q   <= amsen_d;
            d1r_q     <= d1r_d;
            d2r_q     <= d2r_d;
            dt2_q     <= dt2_d;
            d1l_q     <= d1l_d;
            rr_q      <= rr_d;
            kon_q     <= kon_d;
            csm_kon_q <= csm_kon_d;
            csm_cnt_q <= csm_cnt_d;
        end
    end

    assign cycles    = cycles_q;
    assign cur_op    = cycles_q[4:3];
    assign zero      = (cycles_q == 5'd0);
    assign half      = (cycles_q[3:0] == 4'd0);
    assign op31_no   = (cycles_q == 5'd31);
    assign m1_enters = (cur_op == 2'd0);
    assign m2_enters = (cur_op == 2'd1);
    assign c1_enters = (cur_op == 2'd2);
    assign c2_enters = (cur_op == 2'd3);

    assign rl_I    = rl_q[cycles_q[2:0]];
    assign con_I   = con_q[cycles_q[2:0]];
    assign kc_I    = kc_q[cycles_q[2:0]];
    assign kf_I    = kf_q[cycles_q[2:0]];
    assign pms_I   = pms_q[cycles_q[2:0]];
    assign fb_II   = fb_q[s_ii[2:0]];
    assign ams_VII = ams_q[s_vii[2:0]];

    assign dt2_I     = dt2_q[cycles_q];
    assign d1l_I     = d1l_q[cycles_q];
    assign dt1_II    = dt1_q[s_ii];
    assign arate_II  = ar_q[s_ii];
    assign rate1_II  = d1r_q[s_ii];
    assign rate2_II  = d2r_q[s_ii];
    assign rrate_II  = rr_q[s_ii];
    assign keyon_II  = kon_q[s_ii] | csm_kon_q;
    assign ks_III    = ks_q[s_iii];
    assign mul_VI    = mul_q[s_vi];
    assign tl_VII    = tl_q[s_vii];
    assign amsen_VII = amsen_q[s_vii];

    always_comb begin
        use_prevprev1  = 1'b0;
        use_internal_x = 1'b0;
        use_internal_y = 1'b0;
        use_prev2      = 1'b0;
        use_prev1      = 1'b0;
        op31_acc       = 1'b0;
        case (cur_op)
            2'd0: op31_acc = (con_I == 3'd7);
            2'd1: begin
                use_internal_x = (con_I <= 3'd2);
                use_prev1      = (con_I == 3'd1) || (con_I == 3'd5);
                op31_acc       = (con_I >= 3'd5);
            end
            2'd2: begin
                use_prev2 = (con_I != 3'd1) && (con_I != 3'd7);
                op31_acc  = (con_I >= 3'd4);
            end
            default: begin
                use_internal_y = (con_I <= 3'd4);
                use_prevprev1  = (con_I == 3'd2) || (con_I == 3'd5);
                use_prev1      = (con_I == 3'd3);
                op31_acc       = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_jt51_reg_ring.sv
// Directed bench for jt51_reg_ring.
// Expected values are hand-derived from the register map.
module tb_jt51_reg_ring;

    logic       clk = 1'b0;
    logic       rst, cen, csm, overflow_A;
    logic [7:0] din;
    logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl;
    logic       up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
    logic [1:0] op;
    logic [2:0] ch;

    logic [1:0] rl_I, ams_VII, dt2_I, ks_III, cur_op;
    logic [2:0] fb_II, con_I, pms_I, dt1_II;
    logic [6:0] kc_I, tl_VII;
    logic [5:0] kf_I;
    logic [3:0] mul_VI, rrate_II, d1l_I;
    logic [4:0] arate_II, rate1_II, rate2_II, cycles;
    logic       amsen_VII, keyon_II, op31_no, op31_acc, zero, half;
    logic       m1_enters, m2_enters, c1_enters, c2_enters;
    logic       use_prevprev1, use_internal_x, use_internal_y;
    logic       use_prev2, use_prev1;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_cyc;

    jt51_reg_ring dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din),
        .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf),
        .up_pms(up_pms), .up_dt1(up_dt1), .up_tl(up_tl),
        .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2),
        .up_d1l(up_d1l), .up_keyon(up_keyon),
        .op(op), .ch(ch), .csm(csm), .overflow_A(overflow_A),
        .rl_I(rl_I), .fb_II(fb_II), .con_I(con_I), .kc_I(kc_I),
        .kf_I(kf_I), .pms_I(pms_I), .ams_VII(ams_VII),
        .dt1_II(dt1_II), .dt2_I(dt2_I), .mul_VI(mul_VI),
        .tl_VII(tl_VII), .ks_III(ks_III), .arate_II(arate_II),
        .amsen_VII(amsen_VII), .rate1_II(rate1_II),
        .rate2_II(rate2_II), .rrate_II(rrate_II), .d1l_I(d1l_I),
        .keyon_II(keyon_II), .cur_op(cur_op), .op31_no(op31_no),
        .op31_acc(op31_acc), .zero(zero), .half(half),
        .cycles(cycles), .m1_enters(m1_enters),
        .m2_enters(m2_enters), .c1_enters(c1_enters),
        .c2_enters(c2_enters), .use_prevprev1(use_prevprev1),
        .use_internal_x(use_internal_x),
        .use_internal_y(use_internal_y), .use_prev2(use_prev2),
        .use_prev1(use_prev1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cen = 1'b1;
        clk1();
        cen = 1'b0;
        exp_cyc = exp_cyc + 5'd1;
    endtask

    task automatic advance_to(input logic [4:0] n);
        for (int i = 0; i < 32 && exp_cyc != n; i++) step();
        chk("sync_cycles", {27'd0, cycles}, {27'd0, n});
    endtask

    task automatic clear_strobes();
        up_rl = 0; up_kc = 0; up_kf = 0; up_pms = 0; up_dt1 = 0;
        up_tl = 0; up_ks = 0; up_amsen = 0; up_dt2 = 0; up_d1l = 0;
        up_keyon = 0;
    endtask

    initial begin
        clear_strobes();
        rst = 0; cen = 0; csm = 0; overflow_A = 0;
        din = 0; op = 0; ch = 0;
        exp_cyc = 0;
        clk1();
        clk1();
        rst = 1;

        chk("rst_cycles", {27'd0, cycles}, 0);
        chk("rst_zero", {31'd0, zero}, 1);
        chk("rst_half", {31'd0, half}, 1);
        chk("rst_m1", {31'd0, m1_enters}, 1);
        chk("rst_keyon", {31'd0, keyon_II}, 0);
        chk("rst_acc", {31'd0, op31_acc}, 0);
        chk("rst_tl", {25'd0, tl_VII}, 0);

        for (int i = 1; i <= 40; i++) begin
            step();
            chk("cnt_cycles", {27'd0, cycles}, i % 32);
            chk("cnt_zero", {31'd0, zero}, (i % 32) == 0);
            chk("cnt_half", {31'd0, half}, (i % 16) == 0);
            chk("cnt_op31", {31'd0, op31_no}, (i % 32) == 31);
            chk("cnt_enters",
                {28'd0, c2_enters, c1_enters, m2_enters, m1_enters},
                32'd1 << ((i % 32) / 8));
        end

        // 0xC5 -> rl=3 fb=0 con=5 on channel 3
        up_rl = 1; ch = 3; din = 8'hC5;
        clk1();
        clear_strobes();
        advance_to(3);
        chk("ch_rl_I", {30'd0, rl_I}, 3);
        chk("ch_con_I", {29'd0, con_I}, 5);
        advance_to(4);
        chk("ch_fb_II", {29'd0, fb_II}, 0);
        chk("ch_rl_other", {30'd0, rl_I}, 0);

        up_tl = 1; op = 2; ch = 1; din = 8'h7F;
        clk1();
        clear_strobes();
        advance_to(22);
        chk("tl_before", {25'd0, tl_VII}, 0);
        step();
        chk("tl_slot17", {25'd0, tl_VII}, 127);
        step();
        chk("tl_after", {25'd0, tl_VII}, 0);

        // 0xA5 via dt1 and ks in one cycle on slot 5
        up_dt1 = 1; up_ks = 1; op = 0; ch = 5; din = 8'hA5;
        clk1();
        clear_strobes();
        advance_to(6);
        chk("dt1_II", {29'd0, dt1_II}, 2);
        chk("ar_II", {27'd0, arate_II}, 5);
        step();
        chk("ks_III", {30'd0, ks_III}, 2);
        advance_to(10);
        chk("mul_VI", {28'd0, mul_VI}, 5);

        up_keyon = 1; op = 3; ch = 7; din = 8'h7A;
        clk1();
        clear_strobes();
        for (int i = 0; i < 32; i++) begin
            step();
            chk("kon_on", {31'd0, keyon_II}, exp_cyc[2:0] == 3'd3);
        end
        up_keyon = 1; din = 8'h02;
        clk1();
        clear_strobes();
        for (int i = 0; i < 32; i++) begin
            step();
            chk("kon_off", {31'd0, keyon_II}, 0);
        end

        csm = 1; overflow_A = 1;
        clk1();
        csm = 0; overflow_A = 0;
        chk("csm_start", {31'd0, keyon_II}, 1);
        for (int k = 1; k <= 33; k++) begin
            step();
            chk("csm_kon", {31'd0, keyon_II}, k < 32);
        end

        // con=5 on ch0, con=7 on ch1
        up_rl = 1; ch = 0; din = 8'h05;
        clk1();
        ch = 1; din = 8'h07;
        clk1();
        clear_strobes();
        advance_to(0);
        chk("rt_m1_acc", {31'd0, op31_acc}, 0);
        step();
        chk("rt_m1_acc7", {31'd0, op31_acc}, 1);
        advance_to(8);
        chk("rt_m2_prev1", {31'd0, use_prev1}, 1);
        chk("rt_m2_intx", {31'd0, use_internal_x}, 0);
        chk("rt_m2_acc", {31'd0, op31_acc}, 1);
        advance_to(16);
        chk("rt_c1_prev2", {31'd0, use_prev2}, 1);
        chk("rt_c1_acc", {31'd0, op31_acc}, 1);
        step();
        chk("rt_c1_prev2_c7", {31'd0, use_prev2}, 0);
        advance_to(24);
        chk("rt_c2_pp1", {31'd0, use_prevprev1}, 1);
        chk("rt_c2_inty", {31'd0, use_internal_y}, 0);
        chk("rt_c2_prev1", {31'd0, use_prev1}, 0);
        advance_to(0);
        chk("rt_m1_acc_again", {31'd0, op31_acc}, 0);
        chk("rt_m1_flags",
            {27'd0, use_prevprev1, use_internal_x, use_internal_y,
             use_prev2, use_prev1}, 0);

        // reset beats cen and strobes
        rst = 0; cen = 1; up_tl = 1; op = 2; ch = 1; din = 8'h55;
        clk1();
        rst = 1; cen = 0;
        clear_strobes();
        exp_cyc = 0;
        chk("rst2_cycles", {27'd0, cycles}, 0);
        advance_to(23);
        chk("rst2_tl", {25'd0, tl_VII}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
